// File: rtl/conv_bias_arbiter.sv
// conv_bias_arbiter: shares one bias ROM between the conv1 and conv2 layer engines.
//   Each layer has a channel counter that forms its ROM address. conv2 addresses are
//   offset by C2_BASE. Single-cycle read requests are arbitrated, and each bias word
//   comes back tagged to its requester RD_LAT cycles after the grant.
//   Optional macro BIAS_ARB_FIXED_PRIO_EN: conv2 always wins a conflict, with no RR pointer.
//   Default build (macro undefined): round robin.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   l1_req, l1_clr                  conv1 request (level) and restart at channel 0
//   l1_gnt                          conv1 request accepted this cycle (combinational)
//   l1_b_vld, l1_b, l1_last         conv1 bias return, data, last-channel tag
//   l2_*                            same set for conv2
//   rom_en, rom_addr, rom_dout      shared bias ROM read port
module conv_bias_arbiter #(
  parameter int BIAS_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int C1_CH   = 6,
  parameter int C2_CH   = 16,
  parameter int C2_BASE = 6,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1_req,
  input  logic              l1_clr,
  output logic              l1_gnt,
  output logic              l1_b_vld,
  output logic [BIAS_W-1:0] l1_b,
  output logic              l1_last,
  input  logic              l2_req,
  input  logic              l2_clr,
  output logic              l2_gnt,
  output logic              l2_b_vld,
  output logic [BIAS_W-1:0] l2_b,
  output logic              l2_last,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [BIAS_W-1:0] rom_dout
);
  localparam logic [ADDR_W-1:0] L1_MAX = ADDR_W'(C1_CH - 1);
  localparam logic [ADDR_W-1:0] L2_MAX = ADDR_W'(C2_CH - 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(C2_BASE);

  if (C2_BASE < C1_CH || C2_BASE + C2_CH > 2**ADDR_W || RD_LAT < 1 || RD_LAT > 3) begin : g_bad_cfg
    $error("conv_bias_arbiter: illegal parameter set (address map overlap/overflow or RD_LAT out of 1..3)");
  end

  logic [ADDR_W-1:0] r_ch1, r_ch2, r_addr;
  logic [BIAS_W-1:0] r_b1, r_b2;
  logic [RD_LAT-1:0] r_pv, r_po, r_pl;
  logic              w_r1, w_r2, w_last1, w_last2, w_tv, w_to, w_tl;

  // A layer clearing this cycle may not be granted.
  assign w_r1    = l1_req & ~l1_clr;
  assign w_r2    = l2_req & ~l2_clr;
  assign w_last1 = r_ch1 == L1_MAX;
  assign w_last2 = r_ch2 == L2_MAX;

`ifdef BIAS_ARB_FIXED_PRIO_EN
  assign l2_gnt = w_r2;
  assign l1_gnt = w_r1 & ~w_r2;
`else
  // r_rr = 1 means conv2 owns the next conflict; reset favours conv1.
  logic r_rr;
  assign l1_gnt = w_r1 & (~w_r2 | ~r_rr);
  assign l2_gnt = w_r2 & ~l1_gnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rr <= 1'b0;
    else        r_rr <= l1_gnt ? 1'b1 : l2_gnt ? 1'b0 : r_rr;
`endif

  assign rom_en   = l1_gnt | l2_gnt;
  assign rom_addr = l1_gnt ? r_ch1 : l2_gnt ? BASE + r_ch2 : r_addr;

  // Tail of the return pipe lines up with rom_dout for the same read.
  assign w_tv     = r_pv[RD_LAT-1];
  assign w_to     = r_po[RD_LAT-1];
  assign w_tl     = r_pl[RD_LAT-1];
  assign l1_b_vld = w_tv & ~w_to;
  assign l2_b_vld = w_tv & w_to;
  assign l1_last  = l1_b_vld & w_tl;
  assign l2_last  = l2_b_vld & w_tl;
  assign l1_b     = l1_b_vld ? rom_dout : r_b1;
  assign l2_b     = l2_b_vld ? rom_dout : r_b2;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ch1  <= '0;
      r_ch2  <= '0;
      r_addr <= '0;
      r_b1   <= '0;
      r_b2   <= '0;
      r_pv   <= '0;
      r_po   <= '0;
      r_pl   <= '0;
    end else begin
      r_ch1  <= l1_clr ? '0 : l1_gnt ? (w_last1 ? '0 : r_ch1 + 1'b1) : r_ch1;
      r_ch2  <= l2_clr ? '0 : l2_gnt ? (w_last2 ? '0 : r_ch2 + 1'b1) : r_ch2;
      r_addr <= rom_addr;
      r_b1   <= l1_b;
      r_b2   <= l2_b;
      r_pv[0] <= rom_en;
      r_po[0] <= l2_gnt;
      r_pl[0] <= l1_gnt ? w_last1 : l2_gnt & w_last2;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_po[i] <= r_po[i-1];
        r_pl[i] <= r_pl[i-1];
      end
    end
endmodule

// File: tb/tb_conv_bias_arbiter.sv
// tb_conv_bias_arbiter: directed self-checking bench for conv_bias_arbiter (RD_LAT=1 and RD_LAT=3 instances).
module tb_conv_bias_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_l1_req, a_l1_clr, a_l1_gnt, a_l1_b_vld, a_l1_last;
  logic       a_l2_req, a_l2_clr, a_l2_gnt, a_l2_b_vld, a_l2_last;
  logic [7:0] a_l1_b, a_l2_b, a_dout;
  logic       a_en;
  logic [5:0] a_addr;
  logic       b_l1_req, b_l1_clr, b_l1_gnt, b_l1_b_vld, b_l1_last;
  logic       b_l2_req, b_l2_clr, b_l2_gnt, b_l2_b_vld, b_l2_last;
  logic [7:0] b_l1_b, b_l2_b, b_dout;
  logic       b_en;
  logic [5:0] b_addr, b_p1, b_p2;

  conv_bias_arbiter dut_a (
    .clk(clk), .rst_n(rst_n),
    .l1_req(a_l1_req), .l1_clr(a_l1_clr), .l1_gnt(a_l1_gnt), .l1_b_vld(a_l1_b_vld), .l1_b(a_l1_b), .l1_last(a_l1_last),
    .l2_req(a_l2_req), .l2_clr(a_l2_clr), .l2_gnt(a_l2_gnt), .l2_b_vld(a_l2_b_vld), .l2_b(a_l2_b), .l2_last(a_l2_last),
    .rom_en(a_en), .rom_addr(a_addr), .rom_dout(a_dout)
  );

  conv_bias_arbiter #(.RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .l1_req(b_l1_req), .l1_clr(b_l1_clr), .l1_gnt(b_l1_gnt), .l1_b_vld(b_l1_b_vld), .l1_b(b_l1_b), .l1_last(b_l1_last),
    .l2_req(b_l2_req), .l2_clr(b_l2_clr), .l2_gnt(b_l2_gnt), .l2_b_vld(b_l2_b_vld), .l2_b(b_l2_b), .l2_last(b_l2_last),
    .rom_en(b_en), .rom_addr(b_addr), .rom_dout(b_dout)
  );

  function automatic logic [7:0] romf(input logic [5:0] a);
    return {2'b00, a} * 8'd7 + 8'd3;
  endfunction

  always @(posedge clk) begin
    a_dout <= romf(a_addr);
    b_p1   <= b_addr;
    b_p2   <= b_p1;
    b_dout <= romf(b_p2);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       pv, po, pl;
  logic [5:0] pa;

  task automatic tick(input string tag, input logic g1, input logic g2, input logic [5:0] ea, input logic el);
    @(negedge clk);
    chk({tag, " gnt1"}, a_l1_gnt, g1);
    chk({tag, " gnt2"}, a_l2_gnt, g2);
    chk({tag, " rom_en"}, a_en, g1 | g2);
    chk({tag, " rom_addr"}, a_addr, ea);
    chk({tag, " vld1"}, a_l1_b_vld, pv & ~po);
    chk({tag, " vld2"}, a_l2_b_vld, pv & po);
    if (pv) begin
      chk({tag, " data"}, po ? a_l2_b : a_l1_b, romf(pa));
      chk({tag, " last"}, po ? a_l2_last : a_l1_last, pl);
    end
    pv = g1 | g2;
    po = g2;
    pa = ea;
    pl = el;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {a_l1_req, a_l1_clr, a_l2_req, a_l2_clr} = '0;
    {b_l1_req, b_l1_clr, b_l2_req, b_l2_clr} = '0;
    repeat (2) @(negedge clk);
    chk("rst vld1", a_l1_b_vld, 0);
    chk("rst vld2", a_l2_b_vld, 0);
    chk("rst last1", a_l1_last, 0);
    chk("rst b1", a_l1_b, 0);
    chk("rst b2", a_l2_b, 0);
    chk("rst rom_en", a_en, 0);
    chk("rst rom_addr", a_addr, 0);
    chk("rst b vld", {b_l1_b_vld, b_l2_b_vld}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pv = 1'b0;
  endtask

  int n_ret, n_both, j, own, idx;

  initial begin
    pv = 1'b0; po = 1'b0; pl = 1'b0; pa = '0;
    // reset with a read in flight, counter must restart at 0
    do_reset();
    a_l1_req = 1'b1;
    tick("t1 g0", 1, 0, 0, 0);
    tick("t1 g1", 1, 0, 1, 0);
    @(negedge clk);
    chk("t1 g2 gnt1", a_l1_gnt, 1);
    chk("t1 g2 addr", a_addr, 2);
    do_reset();
    tick("t1 idle", 0, 0, 0, 0);
    a_l1_req = 1'b1;
    tick("t1 first", 1, 0, 0, 0);
    a_l1_req = 1'b0;
    tick("t1 drain", 0, 0, 0, 0);
    // conv1 alone for 7 cycles, wrap and last tag
    do_reset();
    a_l1_req = 1'b1;
    for (int i = 0; i < 7; i++) tick("t2", 1, 0, 6'(i % 6), i % 6 == 5);
    a_l1_req = 1'b0;
    tick("t2 drain", 0, 0, 0, 0);
    // both requesting: round robin from reset
    do_reset();
    a_l1_req = 1'b1;
    a_l2_req = 1'b1;
    tick("t3 c0", 1, 0, 0, 0);
    tick("t3 c1", 0, 1, 6, 0);
    tick("t3 c2", 1, 0, 1, 0);
    tick("t3 c3", 0, 1, 7, 0);
    a_l1_req = 1'b0;
    a_l2_req = 1'b0;
    tick("t3 drain", 0, 0, 7, 0);
    // conv2 clear at ch2=5 with a request pending
    do_reset();
    a_l2_req = 1'b1;
    for (int i = 0; i < 5; i++) tick("t5 run", 0, 1, 6'(6 + i), 0);
    a_l2_clr = 1'b1;
    a_l1_req = 1'b1;
    tick("t5 clr", 1, 0, 0, 0);
    a_l2_clr = 1'b0;
    tick("t5 after", 0, 1, 6, 0);
    a_l1_req = 1'b0;
    a_l2_req = 1'b0;
    a_l1_clr = 1'b1;
    tick("t5 idle clr", 0, 0, 6, 0);
    a_l1_clr = 1'b0;
    a_l1_req = 1'b1;
    tick("t5 c1 restart", 1, 0, 0, 0);
    a_l1_req = 1'b0;
    tick("t5 drain", 0, 0, 0, 0);
    // RD_LAT=3 instance, both held 32 cycles
    do_reset();
    n_ret = 0;
    n_both = 0;
    for (int k = 0; k < 35; k++) begin
      b_l1_req = k < 32;
      b_l2_req = k < 32;
      @(negedge clk);
      if (k < 32) begin
        chk("t6 gnt1", b_l1_gnt, k % 2 == 0);
        chk("t6 gnt2", b_l2_gnt, k % 2 == 1);
        chk("t6 addr", b_addr, (k % 2 == 1) ? 6 + (k / 2) % 16 : (k / 2) % 6);
      end
      n_ret += int'(b_l1_b_vld) + int'(b_l2_b_vld);
      n_both += int'(b_l1_b_vld & b_l2_b_vld);
      if (k >= 3) begin
        j = k - 3;
        own = j % 2;
        idx = j / 2;
        chk("t6 vld1", b_l1_b_vld, own == 0);
        chk("t6 vld2", b_l2_b_vld, own == 1);
        chk("t6 data", own == 1 ? b_l2_b : b_l1_b, romf(own == 1 ? 6'(6 + idx % 16) : 6'(idx % 6)));
        chk("t6 last", own == 1 ? b_l2_last : b_l1_last, own == 1 ? idx % 16 == 15 : idx % 6 == 5);
      end else begin
        chk("t6 early vld", {b_l1_b_vld, b_l2_b_vld}, 0);
      end
      @(posedge clk);
      #1;
    end
    chk("t6 returns", n_ret, 32);
    chk("t6 both vld", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
